// File: rtl/bus_protocol_pkg.sv
// Shared definitions for the bus protocol monitor: error indices and the
// priority encoder that picks which error is recorded first.
package bus_protocol_pkg;

  localparam int NUM_ERRORS = 6;
  localparam int ERR_CODE_W = 3;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_OVERFLOW        = 3'd0,
    ERR_READ_UNDERFLOW  = 3'd1,
    ERR_WRITE_UNDERFLOW = 3'd2,
    ERR_REQ_TIMEOUT     = 3'd3,
    ERR_READ_TIMEOUT    = 3'd4,
    ERR_WRITE_TIMEOUT   = 3'd5
  } err_idx_e;

  // Lowest set index wins when several errors fire in the same cycle.
  function automatic logic [ERR_CODE_W-1:0] lowest_error(input logic [NUM_ERRORS-1:0] vec);
    logic [ERR_CODE_W-1:0] idx;
    idx = 3'd0;
    for (int i = NUM_ERRORS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ERR_CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Consecutive-wait counter. Counts cycles in which i_wait holds, saturating at
// TIMEOUT-1; o_fire is asserted on every waiting cycle once saturated, so the
// TIMEOUT-th consecutive waiting cycle is the first one that fires.
module bus_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_wait,
  output logic o_fire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear on any non-waiting cycle, otherwise advance and hold at LAST.
  always_comb begin
    count_d = count_q;
    if (!i_wait) begin
      count_d = {CW{1'b0}};
    end else if (count_q == LAST) begin
      count_d = LAST;
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign o_fire = i_wait & (count_q == LAST);

endmodule

// File: rtl/bus_protocol_monitor.sv
// Passive monitor for the request/address-ack/read-ack/write-ack bus.
// Tracks outstanding reads and writes, checks pipeline depth and completion
// ordering, enforces bounded latency, and keeps sticky error flags plus a
// record of the first error since reset or clear. Drives no bus signals.
module bus_protocol_monitor
  import bus_protocol_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_req,
  input  logic                  i_readWrite_n,
  input  logic                  i_addressAck,
  input  logic                  i_readAck,
  input  logic                  i_writeAck,
  input  logic                  i_clearErrors,
  output logic [CNT_W-1:0]      o_pendingReads,
  output logic [CNT_W-1:0]      o_pendingWrites,
  output logic [NUM_ERRORS-1:0] o_errors,
  output logic                  o_errorPulse,
  output logic [ERR_CODE_W-1:0] o_firstError,
  output logic                  o_firstErrorValid
);

  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]      pending_reads_q, pending_reads_d;
  logic [CNT_W-1:0]      pending_writes_q, pending_writes_d;
  logic [NUM_ERRORS-1:0] errors_q, errors_d;
  logic                  error_pulse_q, error_pulse_d;
  logic [ERR_CODE_W-1:0] first_error_q, first_error_d;
  logic                  first_valid_q, first_valid_d;

  logic                  rd_accept_s, wr_accept_s;
  logic                  rd_inc_s, rd_dec_s, wr_inc_s, wr_dec_s;
  logic                  req_wait_s, rd_wait_s, wr_wait_s;
  logic                  req_fire_s, rd_fire_s, wr_fire_s;
  logic [CNT_W:0]        total_pending_s;
  logic [NUM_ERRORS-1:0] fire_s;

  assign rd_accept_s     = i_req & i_readWrite_n & i_addressAck;
  assign wr_accept_s     = i_req & ~i_readWrite_n & i_addressAck;
  assign total_pending_s = {1'b0, pending_reads_q} + {1'b0, pending_writes_q};

  assign req_wait_s = i_req & ~i_addressAck;
  assign rd_wait_s  = (pending_reads_q != CNT_ZERO) & ~i_readAck;
  assign wr_wait_s  = (pending_writes_q != CNT_ZERO) & ~i_writeAck;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_req_timeout (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .i_wait (req_wait_s),
    .o_fire (req_fire_s)
  );

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_read_timeout (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .i_wait (rd_wait_s),
    .o_fire (rd_fire_s)
  );

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_write_timeout (
    .i_clk  (i_clk),
    .i_srst (i_srst),
    .i_wait (wr_wait_s),
    .o_fire (wr_fire_s)
  );

  // Violation detection for this cycle; completions never free a slot early.
  always_comb begin
    fire_s                      = {NUM_ERRORS{1'b0}};
    fire_s[ERR_OVERFLOW]        = i_addressAck & (total_pending_s == DEPTH_SUM);
    fire_s[ERR_READ_UNDERFLOW]  = i_readAck & (pending_reads_q == CNT_ZERO);
    fire_s[ERR_WRITE_UNDERFLOW] = i_writeAck & (pending_writes_q == CNT_ZERO) & ~wr_accept_s;
    fire_s[ERR_REQ_TIMEOUT]     = req_fire_s;
    fire_s[ERR_READ_TIMEOUT]    = rd_fire_s;
    fire_s[ERR_WRITE_TIMEOUT]   = wr_fire_s;
  end

  // Pending counters: a violating event is dropped in its offending direction.
  always_comb begin
    rd_inc_s = rd_accept_s & ~fire_s[ERR_OVERFLOW];
    rd_dec_s = i_readAck & (pending_reads_q != CNT_ZERO);
    wr_inc_s = wr_accept_s & ~fire_s[ERR_OVERFLOW];
    wr_dec_s = i_writeAck & ((pending_writes_q != CNT_ZERO) | wr_inc_s);

    case ({rd_inc_s, rd_dec_s})
      2'b10:   pending_reads_d = pending_reads_q + CNT_ONE;
      2'b01:   pending_reads_d = pending_reads_q - CNT_ONE;
      default: pending_reads_d = pending_reads_q;
    endcase

    case ({wr_inc_s, wr_dec_s})
      2'b10:   pending_writes_d = pending_writes_q + CNT_ONE;
      2'b01:   pending_writes_d = pending_writes_q - CNT_ONE;
      default: pending_writes_d = pending_writes_q;
    endcase
  end

  // Sticky flags, rising-edge pulse and first-error record; a clear never hides a new error.
  always_comb begin
    errors_d      = (i_clearErrors ? {NUM_ERRORS{1'b0}} : errors_q) | fire_s;
    error_pulse_d = |(errors_d & ~errors_q);
    first_error_d = first_error_q;
    first_valid_d = first_valid_q;
    if ((fire_s != {NUM_ERRORS{1'b0}}) && (!first_valid_q || i_clearErrors)) begin
      first_error_d = lowest_error(fire_s);
      first_valid_d = 1'b1;
    end else if (i_clearErrors) begin
      first_error_d = {ERR_CODE_W{1'b0}};
      first_valid_d = 1'b0;
    end else begin
      first_error_d = first_error_q;
      first_valid_d = first_valid_q;
    end
  end

  // State registers; reset discards all outstanding transactions silently.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      pending_reads_q  <= CNT_ZERO;
      pending_writes_q <= CNT_ZERO;
      errors_q         <= {NUM_ERRORS{1'b0}};
      error_pulse_q    <= 1'b0;
      first_error_q    <= {ERR_CODE_W{1'b0}};
      first_valid_q    <= 1'b0;
    end else begin
      pending_reads_q  <= pending_reads_d;
      pending_writes_q <= pending_writes_d;
      errors_q         <= errors_d;
      error_pulse_q    <= error_pulse_d;
      first_error_q    <= first_error_d;
      first_valid_q    <= first_valid_d;
    end
  end

  assign o_pendingReads    = pending_reads_q;
  assign o_pendingWrites   = pending_writes_q;
  assign o_errors          = errors_q;
  assign o_errorPulse      = error_pulse_q;
  assign o_firstError      = first_error_q;
  assign o_firstErrorValid = first_valid_q;

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Scoreboard bench for bus_protocol_monitor (DEPTH=4, TIMEOUT=8). Stimulus
// pushes the reference model's expected outputs into a queue; a separate
// monitor pops and compares after every clock edge. Directed scenarios are
// followed by randomized phases with different traffic mixes.
module tb_bus_protocol_monitor;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic clk;
  logic i_srst, i_req, i_readWrite_n, i_addressAck, i_readAck, i_writeAck, i_clearErrors;
  logic [CNT_W-1:0] o_pendingReads, o_pendingWrites;
  logic [5:0] o_errors;
  logic o_errorPulse;
  logic [2:0] o_firstError;
  logic o_firstErrorValid;

  bus_protocol_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk             (clk),
    .i_srst            (i_srst),
    .i_req             (i_req),
    .i_readWrite_n     (i_readWrite_n),
    .i_addressAck      (i_addressAck),
    .i_readAck         (i_readAck),
    .i_writeAck        (i_writeAck),
    .i_clearErrors     (i_clearErrors),
    .o_pendingReads    (o_pendingReads),
    .o_pendingWrites   (o_pendingWrites),
    .o_errors          (o_errors),
    .o_errorPulse      (o_errorPulse),
    .o_firstError      (o_firstError),
    .o_firstErrorValid (o_firstErrorValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       pr;
    int       pw;
    bit [5:0] err;
    bit       pulse;
    int       first;
    bit       fvalid;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model state: plain counts and run lengths of waiting cycles.
  int       m_pr, m_pw, m_first;
  bit [5:0] m_err;
  bit       m_pulse, m_fvalid;
  int       run_req, run_rd, run_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit req, input bit rw, input bit aa, input bit ra,
                            input bit wa, input bit clr, input bit rst);
    exp_t e;
    bit [5:0] f;
    bit [5:0] err_n;
    bit rd_acc, wr_acc;
    int pr_n, pw_n;
    if (rst) begin
      m_pr = 0; m_pw = 0; m_err = 6'd0; m_pulse = 1'b0; m_first = 0; m_fvalid = 1'b0;
      run_req = 0; run_rd = 0; run_wr = 0;
    end else begin
      rd_acc = req && rw && aa;
      wr_acc = req && !rw && aa;
      run_req = (req && !aa) ? run_req + 1 : 0;
      run_rd  = (m_pr != 0 && !ra) ? run_rd + 1 : 0;
      run_wr  = (m_pw != 0 && !wa) ? run_wr + 1 : 0;
      f = 6'd0;
      f[0] = aa && (m_pr + m_pw == DEPTH);
      f[1] = ra && (m_pr == 0);
      f[2] = wa && (m_pw == 0) && !wr_acc;
      f[3] = (run_req >= TIMEOUT);
      f[4] = (run_rd >= TIMEOUT);
      f[5] = (run_wr >= TIMEOUT);
      pr_n = m_pr;
      if (rd_acc && !f[0]) pr_n++;
      if (ra && m_pr > 0) pr_n--;
      pw_n = m_pw;
      if (wr_acc && !f[0]) pw_n++;
      if (wa && pw_n > 0) pw_n--;
      err_n = (clr ? 6'd0 : m_err) | f;
      m_pulse = ((err_n & ~m_err) != 6'd0);
      if (f != 6'd0 && (!m_fvalid || clr)) begin
        for (int i = 0; i < 6; i++) begin
          if (f[i]) begin
            m_first = i;
            break;
          end
        end
        m_fvalid = 1'b1;
      end else if (clr) begin
        m_first = 0;
        m_fvalid = 1'b0;
      end
      m_err = err_n;
      m_pr = pr_n;
      m_pw = pw_n;
    end
    e.pr = m_pr; e.pw = m_pw; e.err = m_err; e.pulse = m_pulse;
    e.first = m_first; e.fvalid = m_fvalid;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs away from the sampling edge and record the expectation.
  task automatic cyc(input bit req, input bit rw, input bit aa, input bit ra,
                     input bit wa, input bit clr, input bit rst);
    @(negedge clk);
    i_req = req; i_readWrite_n = rw; i_addressAck = aa;
    i_readAck = ra; i_writeAck = wa; i_clearErrors = clr; i_srst = rst;
    model_step(req, rw, aa, ra, wa, clr, rst);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare every registered output after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pendingReads", 32'(o_pendingReads), 32'(e.pr));
        check("pendingWrites", 32'(o_pendingWrites), 32'(e.pw));
        check("errors", 32'(o_errors), 32'(e.err));
        check("errorPulse", 32'(o_errorPulse), 32'(e.pulse));
        check("firstErrorValid", 32'(o_firstErrorValid), 32'(e.fvalid));
        if (e.fvalid) check("firstError", 32'(o_firstError), 32'(e.first));
      end
    end
  end

  initial begin : stimulus
    int p_req, p_aa, p_ra, p_wa, p_clr, p_rst;
    i_srst = 1'b1; i_req = 1'b0; i_readWrite_n = 1'b0; i_addressAck = 1'b0;
    i_readAck = 1'b0; i_writeAck = 1'b0; i_clearErrors = 1'b0;

    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1); settle();
    check("reset_errors", 32'(o_errors), 32'd0);
    check("reset_pending", 32'(o_pendingReads) + 32'(o_pendingWrites), 32'd0);
    check("reset_valid", 32'(o_firstErrorValid), 32'd0);

    // Four reads fill the pipeline, the fifth address ack overflows.
    repeat (4) cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0); settle();
    check("ovf_pendingReads", 32'(o_pendingReads), 32'd4);
    check("ovf_errors", 32'(o_errors), 32'h01);
    check("ovf_first", 32'(o_firstError), 32'd0);
    check("ovf_pulse", 32'(o_errorPulse), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0); settle();
    check("ovf_pulse_once", 32'(o_errorPulse), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Same-cycle write accept and ack is legal; a lone ack underflows.
    cyc(1, 0, 1, 0, 1, 0, 0); settle();
    check("wbypass_pending", 32'(o_pendingWrites), 32'd0);
    check("wbypass_errors", 32'(o_errors), 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0); settle();
    check("wunder_errors", 32'(o_errors), 32'h04);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Request waits TIMEOUT cycles without acceptance.
    repeat (8) cyc(1, 1, 0, 0, 0, 0, 0);
    settle();
    check("reqto_errors", 32'(o_errors), 32'h08);
    cyc(0, 0, 0, 0, 0, 0, 1);
    repeat (6) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0); settle();
    check("reqto_early_ack", 32'(o_errors), 32'd0);

    // Read withheld for TIMEOUT cycles, then cleared while completing it.
    cyc(1, 1, 1, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rdto_errors", 32'(o_errors), 32'h10);
    cyc(0, 0, 0, 1, 0, 1, 0); settle();
    check("clear_errors", 32'(o_errors), 32'd0);
    check("clear_valid", 32'(o_firstErrorValid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Read underflow coinciding with overflow: lowest index is recorded.
    repeat (4) cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0); settle();
    check("dual_errors", 32'(o_errors), 32'h03);
    check("dual_first", 32'(o_firstError), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Write timeout, then reset mid-operation.
    repeat (3) cyc(1, 0, 1, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("wrto_bit5", 32'(o_errors[5]), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1); settle();
    check("rst_pendingWrites", 32'(o_pendingWrites), 32'd0);
    check("rst_errors", 32'(o_errors), 32'd0);
    check("rst_valid", 32'(o_firstErrorValid), 32'd0);
    repeat (12) cyc(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_no_spurious", 32'(o_errors), 32'd0);

    // Randomized phases: balanced, slow slave, saturated, and busy with clears.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin p_req = 60; p_aa = 60; p_ra = 40; p_wa = 40; p_clr = 5;  p_rst = 1; end
        1:       begin p_req = 50; p_aa = 10; p_ra = 5;  p_wa = 5;  p_clr = 3;  p_rst = 1; end
        2:       begin p_req = 80; p_aa = 70; p_ra = 10; p_wa = 10; p_clr = 3;  p_rst = 0; end
        default: begin p_req = 50; p_aa = 50; p_ra = 50; p_wa = 50; p_clr = 10; p_rst = 2; end
      endcase
      for (int n = 0; n < 700; n++) begin
        cyc($urandom_range(99) < p_req, $urandom_range(1), $urandom_range(99) < p_aa,
            $urandom_range(99) < p_ra, $urandom_range(99) < p_wa,
            $urandom_range(99) < p_clr, $urandom_range(99) < p_rst);
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
